// File: rtl/log_flag_monitor.sv
// Registers the five logic-block flags, emits rising-edge pulses, keeps saturating
// per-flag edge counts and hands out a snapshot of the counts over valid/ready.
module log_flag_monitor #(
  parameter int CNT_W       = 8,
  parameter bit CLR_ON_SNAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         flags_in,
  input  logic               sample_en,
  input  logic               snap_req,
  input  logic               snap_ready,
  output logic [4:0]         flags_q,
  output logic [4:0]         rise,
  output logic               snap_valid,
  output logic [5*CNT_W-1:0] snap_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, VALID} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt      [5];
  logic [CNT_W-1:0] cnt_base [5];
  logic [CNT_W-1:0] cnt_nxt  [5];
  logic [4:0]       inc;

  assign inc = sample_en ? (flags_in & ~flags_q) : 5'b00000;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap_req) state_nxt = CAPTURE;
      CAPTURE: state_nxt = VALID;
      VALID:   if (snap_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An edge arriving in the capture cycle lands in the new window, not the snapshot.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_base[i] = (state == CAPTURE && CLR_ON_SNAP) ? '0 : cnt[i];
      cnt_nxt[i]  = (inc[i] && cnt_base[i] != CNT_MAX) ? cnt_base[i] + CNT_W'(1) : cnt_base[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flags_q  <= '0;
      rise     <= '0;
      snap_cnt <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      rise  <= inc;
      if (sample_en) flags_q <= flags_in;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (state == CAPTURE) snap_cnt[i*CNT_W +: CNT_W] <= cnt[i];
      end
    end
  end

  assign snap_valid = (state == VALID);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_log_flag_monitor.sv
// Bench for log_flag_monitor: two instances (clear-on-snapshot on and off) against
// an edge-counting reference model, plus directed cases with literal expectations.
module tb_log_flag_monitor;

  localparam int W    = 8;
  localparam int MAXC = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [4:0]   flags_in = '0;
  logic         sample_en = 1'b0, snap_req = 1'b0, snap_ready = 1'b0;

  logic [4:0]   a_fq, a_rise, b_fq, b_rise;
  logic         a_sv, a_bz, b_sv, b_bz;
  logic [5*W-1:0] a_sc, b_sc;

  int n_checks = 0;
  int n_fail   = 0;

  log_flag_monitor #(.CNT_W(W), .CLR_ON_SNAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flags_in(flags_in), .sample_en(sample_en),
    .snap_req(snap_req), .snap_ready(snap_ready), .flags_q(a_fq), .rise(a_rise),
    .snap_valid(a_sv), .snap_cnt(a_sc), .busy(a_bz));

  log_flag_monitor #(.CNT_W(W), .CLR_ON_SNAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flags_in(flags_in), .sample_en(sample_en),
    .snap_req(snap_req), .snap_ready(snap_ready), .flags_q(b_fq), .rise(b_rise),
    .snap_valid(b_sv), .snap_cnt(b_sc), .busy(b_bz));

  always #5 clk = ~clk;

  // Reference: edge counts per window; index 0 clears on snapshot, index 1 does not.
  int         m_cnt  [2][5] = '{default: 0};
  int         m_snap [2][5] = '{default: 0};
  logic [4:0] m_fq = '0, m_rise = '0;
  bit         capturing = 0;   // the cycle in which the snapshot is being taken
  bit         holding   = 0;   // snapshot offered to the consumer

  always @(posedge clk or posedge rst) begin : model
    logic [4:0] edges;
    int base;
    if (rst) begin
      m_cnt = '{default: 0}; m_snap = '{default: 0};
      m_fq = '0; m_rise = '0; capturing = 0; holding = 0;
    end else begin
      edges = sample_en ? (flags_in & ~m_fq) : 5'b0;
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 5; i++) begin
          if (capturing) m_snap[c][i] = m_cnt[c][i];
          base = (capturing && c == 0) ? 0 : m_cnt[c][i];
          m_cnt[c][i] = (edges[i] && base < MAXC) ? base + 1 : base;
        end
      m_rise = edges;
      if (sample_en) m_fq = flags_in;
      if (capturing) begin
        capturing = 0; holding = 1;
      end else if (holding) begin
        if (snap_ready) holding = 0;
      end else if (snap_req) begin
        capturing = 1;
      end
    end
  end

  function automatic logic [5*W-1:0] exp_snap(int c);
    logic [5*W-1:0] v = '0;
    for (int i = 0; i < 5; i++) v[i*W +: W] = W'(m_snap[c][i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_flags_q",    64'(a_fq),   64'(m_fq));
    check("a_rise",       64'(a_rise), 64'(m_rise));
    check("a_snap_valid", 64'(a_sv),   64'(holding));
    check("a_busy",       64'(a_bz),   64'(capturing | holding));
    check("a_snap_cnt",   64'(a_sc),   64'(exp_snap(0)));
    check("b_flags_q",    64'(b_fq),   64'(m_fq));
    check("b_rise",       64'(b_rise), 64'(m_rise));
    check("b_snap_valid", 64'(b_sv),   64'(holding));
    check("b_busy",       64'(b_bz),   64'(capturing | holding));
    check("b_snap_cnt",   64'(b_sc),   64'(exp_snap(1)));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic get_snap();
    snap_req = 1'b1; step(); snap_req = 1'b0;
    for (int k = 0; k < 8 && a_sv !== 1'b1; k++) step();
    check("snap_valid_wait", 64'(a_sv), 64'd1);
  endtask

  task automatic release_snap();
    snap_ready = 1'b1; step(); snap_ready = 1'b0;
    check("a_valid_drop", 64'(a_sv), 64'd0);
    check("a_busy_drop",  64'(a_bz), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step(); rst = 1'b0;

    // Async reset with inputs toggling: outputs clear immediately, mid-cycle.
    for (int n = 0; n < 20; n++) begin
      flags_in = 5'($urandom); sample_en = 1'b1; snap_req = n[2]; snap_ready = 1'b0;
      step();
    end
    #2 rst = 1'b1;
    #1;
    check("rst_flags_q", 64'(a_fq), 64'd0);
    check("rst_rise",    64'(a_rise), 64'd0);
    check("rst_valid",   64'(a_sv), 64'd0);
    check("rst_busy",    64'(a_bz), 64'd0);
    check("rst_snap",    64'(a_sc), 64'd0);
    snap_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Single edge on x.
    sample_en = 1'b1; flags_in = 5'b00000; step(); step();
    flags_in = 5'b00100; step();
    check("single_rise",    64'(a_rise), 64'h04);
    check("single_flags_q", 64'(a_fq),   64'h04);
    step();
    check("single_rise_off", 64'(a_rise), 64'h00);
    step(); step(); step();
    get_snap();
    check("single_snap_a", 64'(a_sc), 64'h00_00_01_00_00);
    check("single_snap_b", 64'(b_sc), 64'h00_00_01_00_00);
    release_snap();

    // Saturation of z after 300 edges; x held high adds nothing.
    for (int n = 0; n < 300; n++) begin
      flags_in = 5'b00100; step();
      flags_in = 5'b00101; step();
    end
    sample_en = 1'b0;
    flags_in = 5'b00100; step();
    flags_in = 5'b00101; step();
    check("no_sample_rise", 64'(a_rise), 64'h00);
    get_snap();
    check("sat_snap_a", 64'(a_sc), 64'h00_00_00_00_FF);
    check("sat_snap_b", 64'(b_sc), 64'h00_00_01_00_FF);
    release_snap();

    // Backpressure with u=3, y=7.
    do_reset();
    sample_en = 1'b1; flags_in = 5'b0; step();
    for (int n = 0; n < 7; n++) begin
      flags_in = {(n < 3), 3'b001, 1'b0}; step();
      flags_in = 5'b0; step();
    end
    get_snap();
    for (int n = 0; n < 4; n++) begin
      snap_req = (n == 1);
      step();
      check("bp_valid", 64'(a_sv), 64'd1);
      check("bp_snap",  64'(a_sc), 64'h03_00_00_07_00);
    end
    snap_req = 1'b0;
    release_snap();
    step();
    check("bp_no_rereq", 64'(a_bz), 64'd0);

    // Edge on x lands in the capture cycle.
    do_reset();
    sample_en = 1'b1; flags_in = 5'b0; step();
    for (int n = 0; n < 5; n++) begin
      flags_in = 5'b00100; step();
      flags_in = 5'b00000; step();
    end
    snap_req = 1'b1; step();
    snap_req = 1'b0; flags_in = 5'b00100; step();
    check("coll_valid",  64'(a_sv), 64'd1);
    check("coll_snap_a", 64'(a_sc), 64'h00_00_05_00_00);
    check("coll_snap_b", 64'(b_sc), 64'h00_00_05_00_00);
    release_snap();
    get_snap();
    check("coll_next_a", 64'(a_sc), 64'h00_00_01_00_00);
    check("coll_next_b", 64'(b_sc), 64'h00_00_06_00_00);

    // Reset while the snapshot is being offered.
    #2 rst = 1'b1;
    #1;
    check("rv_valid", 64'(a_sv), 64'd0);
    check("rv_snap",  64'(b_sc), 64'd0);
    sample_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    get_snap();
    check("rv_zero_a", 64'(a_sc), 64'd0);
    check("rv_zero_b", 64'(b_sc), 64'd0);
    release_snap();

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      flags_in   = 5'($urandom);
      sample_en  = ($urandom_range(0, 3) != 0);
      snap_req   = ($urandom_range(0, 7) == 0);
      snap_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
